// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADC scan sequencer.
// The ADC_SCAN_AVG_EN build option uses AVG_SAMPLES.
package adc_pkg;

  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned DATA_W      = 12;
  localparam int unsigned CH_W        = 3;
  localparam int unsigned AVG_SAMPLES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StGuard,
    StWait,
    StStore,
    StGap
  } adc_state_e;

endpackage

// File: rtl/adc_next_ch.sv
// Channel picker: next set channel above cur_ch_i, a wrap flag when none is
// higher, and the lowest set channel of mask_i.
module adc_next_ch
  import adc_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   cur_ch_i,
  output logic [CH_W-1:0]   next_ch_o,
  output logic              wrap_o,
  output logic [CH_W-1:0]   low_ch_o
);

  always_comb begin
    next_ch_o = '0;
    wrap_o    = 1'b1;
    low_ch_o  = '0;
    // Descending scans so the last match left standing is the lowest one.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        low_ch_o = CH_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (CH_W'(i) > cur_ch_i)) begin
        next_ch_o = CH_W'(i);
        wrap_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin LTC2308 scan sequencer with result bank, gap and timeout.
// Define ADC_SCAN_AVG_EN to average AVG_SAMPLES conversions per channel.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     clr_err,
  output logic                     measure_start,
  output logic [CH_W-1:0]          measure_ch,
  input  logic                     measure_done,
  input  logic [DATA_W-1:0]        measured_data,
  output logic [NUM_CH*DATA_W-1:0] result,
  output logic [NUM_CH-1:0]        result_valid,
  output logic                     sample_valid,
  output logic [CH_W-1:0]          sample_ch,
  output logic                     scan_done,
  output logic                     timeout_err,
  output logic                     busy
);

  localparam int unsigned CntMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  adc_state_e               state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [CH_W-1:0]          cur_ch_q, cur_ch_d;
  logic [NUM_CH-1:0]        scan_mask_q, scan_mask_d;
  logic [NUM_CH*DATA_W-1:0] result_q, result_d;
  logic [NUM_CH-1:0]        result_valid_q, result_valid_d;
  logic                     sample_valid_q, sample_valid_d;
  logic [CH_W-1:0]          sample_ch_q, sample_ch_d;
  logic                     scan_done_q, scan_done_d;
  logic                     timeout_err_q, timeout_err_d;
  logic                     measure_start_q, measure_start_d;
  logic                     wrap_pending_q, wrap_pending_d;

  logic [NUM_CH-1:0] mask_sel;
  logic [CH_W-1:0]   next_ch, low_ch;
  logic              wrap;
  logic              wr, adv;
  logic [DATA_W-1:0] wdata;

`ifdef ADC_SCAN_AVG_EN
  localparam int unsigned RepW = $clog2(AVG_SAMPLES);
  localparam int unsigned SumW = DATA_W + RepW;
  logic [RepW-1:0] rep_q, rep_d;
  logic [SumW-1:0] sum_q, sum_d, sum_add;
  assign sum_add = sum_q + SumW'(measured_data);
`endif

  // At scan boundaries the picker looks at the live mask so the restart channel
  // comes from the freshly latched value.
  assign mask_sel = ((state_q == StIdle) || ((state_q == StGap) && wrap_pending_q)) ?
                    ch_mask : scan_mask_q;

  adc_next_ch u_next_ch (
    .mask_i    (mask_sel),
    .cur_ch_i  (cur_ch_q),
    .next_ch_o (next_ch),
    .wrap_o    (wrap),
    .low_ch_o  (low_ch)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CntW'(1);
    cur_ch_d       = cur_ch_q;
    scan_mask_d    = scan_mask_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    scan_done_d    = 1'b0;
    timeout_err_d  = clr_err ? 1'b0 : timeout_err_q;
    wrap_pending_d = wrap_pending_q;
    wr             = 1'b0;
    wdata          = measured_data;
    adv            = 1'b1;
`ifdef ADC_SCAN_AVG_EN
    rep_d          = rep_q;
    sum_d          = sum_q;
    adv            = (rep_q == '0);
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable && (ch_mask != '0)) begin
          scan_mask_d = ch_mask;
          cur_ch_d    = low_ch;
          state_d     = StStart;
        end
      end
      StStart: begin
        cnt_d   = '0;
        state_d = StGuard;
      end
      StGuard: begin
        if (cnt_q == CntW'(1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (measure_done) begin
          state_d = StStore;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d  = 1'b1;
          scan_done_d    = wrap;
          wrap_pending_d = wrap;
          cnt_d          = '0;
          state_d        = StGap;
`ifdef ADC_SCAN_AVG_EN
          rep_d          = '0;
          sum_d          = '0;
`endif
        end
      end
      StStore: begin
        cnt_d   = '0;
        state_d = StGap;
`ifdef ADC_SCAN_AVG_EN
        if (rep_q == RepW'(AVG_SAMPLES - 1)) begin
          wr    = 1'b1;
          wdata = sum_add[SumW-1:RepW];
          rep_d = '0;
          sum_d = '0;
        end else begin
          rep_d = rep_q + RepW'(1);
          sum_d = sum_add;
        end
`else
        wr = 1'b1;
`endif
        if (wr) begin
          sample_valid_d = 1'b1;
          sample_ch_d    = cur_ch_q;
          scan_done_d    = wrap;
          wrap_pending_d = wrap;
        end
      end
      StGap: begin
        if (!enable) begin
          cnt_d          = '0;
          wrap_pending_d = 1'b0;
          state_d        = StIdle;
`ifdef ADC_SCAN_AVG_EN
          rep_d          = '0;
          sum_d          = '0;
`endif
        end else if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          cnt_d          = '0;
          wrap_pending_d = 1'b0;
          state_d        = StStart;
          if (adv) begin
            if (wrap_pending_q) begin
              scan_mask_d = ch_mask;
              if (ch_mask == '0) begin
                state_d = StIdle;
              end else begin
                cur_ch_d = low_ch;
              end
            end else begin
              cur_ch_d = next_ch;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (CH_W'(i) == cur_ch_q) begin
          result_d[i*DATA_W +: DATA_W] = wdata;
          result_valid_d[i]            = 1'b1;
        end
      end
    end

    measure_start_d = (state_d == StStart);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      cur_ch_q        <= '0;
      scan_mask_q     <= '0;
      result_q        <= '0;
      result_valid_q  <= '0;
      sample_valid_q  <= 1'b0;
      sample_ch_q     <= '0;
      scan_done_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
      measure_start_q <= 1'b0;
      wrap_pending_q  <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      rep_q           <= '0;
      sum_q           <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cur_ch_q        <= cur_ch_d;
      scan_mask_q     <= scan_mask_d;
      result_q        <= result_d;
      result_valid_q  <= result_valid_d;
      sample_valid_q  <= sample_valid_d;
      sample_ch_q     <= sample_ch_d;
      scan_done_q     <= scan_done_d;
      timeout_err_q   <= timeout_err_d;
      measure_start_q <= measure_start_d;
      wrap_pending_q  <= wrap_pending_d;
`ifdef ADC_SCAN_AVG_EN
      rep_q           <= rep_d;
      sum_q           <= sum_d;
`endif
    end
  end

  assign measure_start = measure_start_q;
  assign measure_ch    = cur_ch_q;
  assign result        = result_q;
  assign result_valid  = result_valid_q;
  assign sample_valid  = sample_valid_q;
  assign sample_ch     = sample_ch_q;
  assign scan_done     = scan_done_q;
  assign timeout_err   = timeout_err_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: ADC model, table-driven scans, directed corner
// cases and a randomized run against a conversion-log reference model.
module tb_adc_scan_sequencer;

  localparam int GapC = 4;
  localparam int ToC  = 64;
`ifdef ADC_SCAN_AVG_EN
  localparam int Reps = 4;
`else
  localparam int Reps = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic        clr_err = 1'b0;
  logic        measure_start;
  logic [2:0]  measure_ch;
  logic        measure_done;
  logic [11:0] measured_data;
  logic [95:0] result;
  logic [7:0]  result_valid;
  logic        sample_valid;
  logic [2:0]  sample_ch;
  logic        scan_done;
  logic        timeout_err;
  logic        busy;

  adc_scan_sequencer #(
    .GAP_CYCLES     (GapC),
    .TIMEOUT_CYCLES (ToC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .ch_mask       (ch_mask),
    .clr_err       (clr_err),
    .measure_start (measure_start),
    .measure_ch    (measure_ch),
    .measure_done  (measure_done),
    .measured_data (measured_data),
    .result        (result),
    .result_valid  (result_valid),
    .sample_valid  (sample_valid),
    .sample_ch     (sample_ch),
    .scan_done     (scan_done),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // ADC model: done after lat cycles, cleared by start; logs every conversion.
  typedef struct {
    logic [2:0]  ch;
    logic [11:0] d;
  } conv_t;
  conv_t conv_q[$];
  int    lat = 20;
  int    mode = 0;
  logic  hang = 1'b0;
  int    cd;
  logic [2:0] mch;
  int    repn[8];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      measure_done  <= 1'b0;
      measured_data <= '0;
      cd            <= 0;
      for (int i = 0; i < 8; i++) repn[i] = 0;
    end else if (measure_start) begin
      measure_done <= 1'b0;
      cd           <= lat;
      mch          <= measure_ch;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1 && !hang) begin
        automatic logic [11:0] v;
        case (mode)
          0: v = 12'h100 + 12'(mch);
          1: begin
            v = 12'h100 + 12'(repn[mch]);
            repn[mch] = (repn[mch] + 1) % 4;
          end
          default: v = 12'($urandom);
        endcase
        measure_done  <= 1'b1;
        measured_data <= v;
        conv_q.push_back('{ch: mch, d: v});
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait expired, got timeout expected event", name);
  endtask

  // Reference model: expected start order and result bank from conversion log.
  logic [11:0] mres[8];
  logic [7:0]  mvalid;
  logic [2:0]  order_q[$];
  int          conv_base = 0;
  logic        fresh = 1'b1;
  logic        chk_order = 1'b1;
  int          starts_cnt = 0;
  int          writes = 0;
  logic [2:0]  last_start_ch;
  logic [2:0]  last_done_ch;

  function automatic logic [95:0] model_bank();
    logic [95:0] b;
    for (int i = 0; i < 8; i++) b[i*12 +: 12] = mres[i];
    return b;
  endfunction

  task automatic monitor();
    if (!reset_n) begin
      mvalid = '0;
      for (int i = 0; i < 8; i++) mres[i] = '0;
      order_q.delete();
      conv_base = conv_q.size();
      return;
    end
    if (measure_start) begin
      starts_cnt++;
      last_start_ch = measure_ch;
      if (fresh) begin
        order_q.delete();
        conv_base = conv_q.size();
        fresh = 1'b0;
      end
      if (chk_order) begin
        if (order_q.size() == 0) begin
          for (int c = 0; c < 8; c++)
            if (ch_mask[c]) for (int r = 0; r < Reps; r++) order_q.push_back(3'(c));
        end
        if (order_q.size() > 0) check("start_ch", 96'(measure_ch), 96'(order_q.pop_front()));
      end
    end
    if (sample_valid) begin
      writes++;
      if (conv_q.size() - conv_base < Reps) begin
        check("conv_count", 96'(conv_q.size() - conv_base), 96'(Reps));
      end else begin
        automatic int sum = 0;
        for (int k = conv_q.size() - Reps; k < conv_q.size(); k++) begin
          check("conv_ch", 96'(conv_q[k].ch), 96'(sample_ch));
          sum += int'(conv_q[k].d);
        end
        mres[sample_ch] = 12'(sum / Reps);
        mvalid[sample_ch] = 1'b1;
        conv_base = conv_q.size();
      end
      check("bank", result, model_bank());
      check("valid_bits", 96'(result_valid), 96'(mvalid));
    end
    if (scan_done && sample_valid) last_done_ch = sample_ch;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    clr_err = 1'b0;
    hang    = 1'b0;
    fresh   = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) bound_fail("wait_idle");
  endtask

  task automatic wait_scan_done(input int budget);
    int n = 0;
    bit ok = 0;
    while (!ok && n < budget) begin
      tick();
      n++;
      if (scan_done) ok = 1;
    end
    if (!ok) bound_fail("wait_scan_done");
  endtask

  task automatic wait_start_ch(input logic [2:0] c, input int budget);
    int n = 0;
    bit ok = 0;
    while (!ok && n < budget) begin
      tick();
      n++;
      if (measure_start && measure_ch == c) ok = 1;
    end
    if (!ok) bound_fail("wait_start_ch");
  endtask

  typedef struct {
    logic [7:0] mask;
    int         lat;
    logic [7:0] exp_valid;
    int         exp_writes;
    logic [2:0] exp_last;
  } vec_t;
  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h81, 20, 8'h81, 2, 3'd7};
    vecs[1] = '{8'hFF, 20, 8'hFF, 8, 3'd7};
    vecs[2] = '{8'h01, 5,  8'h01, 1, 3'd0};
    vecs[3] = '{8'h2C, 12, 8'h2C, 3, 3'd5};
    vecs[4] = '{8'hF0, 3,  8'hF0, 4, 3'd7};

    do_reset();
    check("reset_bank", result, 96'h0);
    check("reset_outs", 96'({measure_start, measure_ch, result_valid, sample_valid, sample_ch,
                             scan_done, timeout_err, busy}), 96'h0);

    // One full scan per table row, expected bank is 0x100+ch on each set bit.
    for (int v = 0; v < 5; v++) begin
      automatic logic [95:0] eb = '0;
      do_reset();
      mode    = 0;
      lat     = vecs[v].lat;
      ch_mask = vecs[v].mask;
      writes  = 0;
      enable  = 1'b1;
      wait_scan_done(5000);
      enable = 1'b0;
      wait_idle(200);
      for (int c = 0; c < 8; c++) if (vecs[v].exp_valid[c]) eb[c*12 +: 12] = 12'h100 + 12'(c);
      check("tbl_valid", 96'(result_valid), 96'(vecs[v].exp_valid));
      check("tbl_writes", 96'(writes), 96'(vecs[v].exp_writes));
      check("tbl_last_ch", 96'(last_done_ch), 96'(vecs[v].exp_last));
      check("tbl_bank", result, eb);
    end

    // Empty mask: nothing starts.
    do_reset();
    ch_mask    = 8'h00;
    enable     = 1'b1;
    starts_cnt = 0;
    repeat (200) tick();
    check("mask0_starts", 96'(starts_cnt), 96'h0);
    check("mask0_busy", 96'(busy), 96'h0);

    // Drop enable during ch3 WAIT: ch3 conversion finishes, ch4 never starts.
    do_reset();
    lat     = 20;
    ch_mask = 8'hFF;
    enable  = 1'b1;
    wait_start_ch(3'd3, 2000);
    repeat (5) tick();
    enable = 1'b0;
    wait_idle(200);
    repeat (20) tick();
    check("endrop_last_start", 96'(last_start_ch), 96'd3);
`ifdef ADC_SCAN_AVG_EN
    check("endrop_valid", 96'(result_valid), 96'h07);
`else
    check("endrop_valid", 96'(result_valid), 96'h0F);
    check("endrop_ch3", 96'(result[47:36]), 96'h103);
`endif

    // Hung ADC: timeout 3 + ToC cycles after start, then the next channel.
    do_reset();
    chk_order = 1'b0;
    hang      = 1'b1;
    ch_mask   = 8'h06;
    enable    = 1'b1;
    wait_start_ch(3'd1, 100);
    begin
      automatic int n = 0;
      while (!timeout_err && n < 200) begin
        tick();
        n++;
      end
      if (!timeout_err) bound_fail("timeout_wait");
      else check("timeout_latency", 96'(n), 96'(3 + ToC));
    end
    check("timeout_valid", 96'(result_valid), 96'h0);
    check("timeout_bank", result, 96'h0);
    wait_start_ch(3'd2, 20);
    check("timeout_sticky", 96'(timeout_err), 96'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
    check("clr_err", 96'(timeout_err), 96'h0);
    enable = 1'b0;
    wait_idle(300);
    hang      = 1'b0;
    chk_order = 1'b1;

    // Ramp data on ch2: averaged build stores (0x100+..+0x103)/4.
    do_reset();
    mode    = 1;
    ch_mask = 8'h04;
    writes  = 0;
    enable  = 1'b1;
    wait_scan_done(2000);
    enable = 1'b0;
    wait_idle(200);
    check("avg_writes", 96'(writes), 96'h1);
`ifdef ADC_SCAN_AVG_EN
    check("avg_ch2", 96'(result[35:24]), 96'h101);
`else
    check("avg_ch2", 96'(result[35:24]), 96'h100);
`endif

    // Asynchronous reset during ch5 WAIT, then restart at the lowest mask bit.
    do_reset();
    mode    = 0;
    ch_mask = 8'h2C;
    enable  = 1'b1;
    wait_start_ch(3'd5, 2000);
    repeat (8) tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_bank", result, 96'h0);
    check("rst_outs", 96'({measure_start, measure_ch, result_valid, sample_valid, sample_ch,
                           scan_done, timeout_err, busy}), 96'h0);
    tick();
    fresh   = 1'b1;
    reset_n = 1'b1;
    wait_start_ch(3'd2, 50);
    enable = 1'b0;
    wait_idle(200);

    // Randomized masks, latencies and data; monitor checks order and bank.
    mode = 2;
    for (int t = 0; t < 20; t++) begin
      ch_mask = 8'($urandom_range(1, 255));
      lat     = int'($urandom_range(3, 40));
      fresh   = 1'b1;
      enable  = 1'b1;
      repeat (int'($urandom_range(300, 1500))) tick();
      enable = 1'b0;
      wait_idle(300);
    end
    check("rand_bank", result, model_bank());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
